// File: rtl/multi_cycle_cu_pkg.sv
`default_nettype none
//============================================================================
// Module   : multi_cycle_cu_pkg
// Brief    : Shared opcode/funct/ALU/select constants and FSM state encoding
// Revision : 1.0 - initial release
//============================================================================
package multi_cycle_cu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FUNCT_SLL = 6'b000000;
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b110;

   localparam logic [1:0] PC_NEXT = 2'b00;
   localparam logic [1:0] PC_REL  = 2'b01;
   localparam logic [1:0] PC_JUMP = 2'b10;
   localparam logic [1:0] PC_HOLD = 2'b11;

   localparam logic REG_FROM_RT = 1'b0;
   localparam logic REG_FROM_RD = 1'b1;
   localparam logic DB_FROM_ALU = 1'b0;
   localparam logic DB_FROM_MEM = 1'b1;
   localparam logic EXT_ZERO    = 1'b0;
   localparam logic EXT_SIGN    = 1'b1;

   typedef enum logic [2:0] {
      STATE_IF   = 3'd0,
      STATE_ID   = 3'd1,
      STATE_EXE  = 3'd2,
      STATE_MEM  = 3'd3,
      STATE_WB   = 3'd4,
      STATE_HALT = 3'd5
   } state_t;

   function automatic logic is_branch(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ);
   endfunction

endpackage : multi_cycle_cu_pkg
`default_nettype wire

// File: rtl/mcu_alu_decode.sv
`default_nettype none
//============================================================================
// Module   : mcu_alu_decode
// Brief    : Combinational Opcode/Funct -> ALUOp, ALU source and extend select
// Revision : 1.0 - initial release
//============================================================================
module mcu_alu_decode
   import multi_cycle_cu_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_op,
   output logic       o_alu_src_a,
   output logic       o_alu_src_b,
   output logic       o_ext_sel
);

   always_comb begin
      o_alu_op    = ALU_ADD;
      o_alu_src_a = 1'b0;
      o_alu_src_b = 1'b0;
      o_ext_sel   = EXT_ZERO;
      unique case (i_opcode)
         OP_ADDI: begin
            o_alu_src_b = 1'b1;
            o_ext_sel   = EXT_SIGN;
         end
         OP_ORI: begin
            o_alu_op    = ALU_OR;
            o_alu_src_b = 1'b1;
         end
         OP_LW, OP_SW: begin
            o_alu_src_b = 1'b1;
            o_ext_sel   = EXT_SIGN;
         end
         OP_BEQ, OP_BNE, OP_BGTZ: begin
            o_alu_op  = ALU_SUB;
            o_ext_sel = EXT_SIGN;
         end
         // R-type and any unrecognised opcode share the funct decode
         default: begin
            unique case (i_funct)
               FUNCT_SUB: o_alu_op = ALU_SUB;
               FUNCT_AND: o_alu_op = ALU_AND;
               FUNCT_OR:  o_alu_op = ALU_OR;
               FUNCT_SLT: o_alu_op = ALU_SLT;
               FUNCT_SLL: begin
                  o_alu_op    = ALU_SLL;
                  o_alu_src_a = 1'b1;
               end
               default:   o_alu_op = ALU_ADD;
            endcase
            if (i_opcode != OP_RTYPE) begin
               o_alu_op    = ALU_ADD;
               o_alu_src_a = 1'b0;
            end
         end
      endcase
   end

endmodule : mcu_alu_decode
`default_nettype wire

// File: rtl/multi_cycle_cu.sv
`default_nettype none
//============================================================================
// Module   : multi_cycle_cu
// Brief    : Multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB/HALT).
//            Define MCU_MEM_WAIT_EN to add the MemReady wait-state input.
// Revision : 1.0 - initial release
//============================================================================
module multi_cycle_cu
   import multi_cycle_cu_pkg::*;
#(
   parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       Sign,
`ifdef MCU_MEM_WAIT_EN
   input  logic       MemReady,
`endif
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic       RegDst,
   output logic       DB,
   output logic       ExtSel,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUOp,
   output logic [2:0] State
);

   state_t     r_state;
   state_t     w_next;
   logic [2:0] w_dec_alu_op;
   logic       w_dec_src_a;
   logic       w_dec_src_b;
   logic       w_dec_ext;
   logic       w_taken;
   logic       w_mem_ready;

`ifdef MCU_MEM_WAIT_EN
   assign w_mem_ready = MemReady;
`else
   assign w_mem_ready = 1'b1;
`endif

   mcu_alu_decode u_alu_decode (
      .i_opcode    (Opcode),
      .i_funct     (Funct),
      .o_alu_op    (w_dec_alu_op),
      .o_alu_src_a (w_dec_src_a),
      .o_alu_src_b (w_dec_src_b),
      .o_ext_sel   (w_dec_ext)
   );

   always_comb begin
      unique case (Opcode)
         OP_BEQ:  w_taken = Zero;
         OP_BNE:  w_taken = !Zero;
         OP_BGTZ: w_taken = !Zero && !Sign;
         default: w_taken = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) r_state <= STATE_IF;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 1'b0;
      RegDst   = REG_FROM_RT;
      DB       = DB_FROM_ALU;
      ExtSel   = EXT_ZERO;
      MemRead  = 1'b1;
      MemWrite = 1'b1;
      RegWrite = 1'b0;
      PCSrc    = PC_NEXT;
      ALUOp    = ALU_ADD;
      unique case (r_state)
         STATE_IF: begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            w_next  = STATE_ID;
         end
         STATE_ID: begin
            if (Opcode == HALT_OPCODE) begin
               w_next = STATE_HALT;
            end else if (Opcode == OP_J) begin
               PCWrite = 1'b1;
               PCSrc   = PC_JUMP;
               w_next  = STATE_IF;
            end else begin
               w_next = STATE_EXE;
            end
         end
         STATE_EXE: begin
            ALUOp   = w_dec_alu_op;
            ALUSrcA = w_dec_src_a;
            ALUSrcB = w_dec_src_b;
            ExtSel  = w_dec_ext;
            if (is_branch(Opcode)) begin
               PCSrc   = PC_REL;
               PCWrite = w_taken;
               w_next  = STATE_IF;
            end else if (Opcode == OP_LW || Opcode == OP_SW) begin
               w_next = STATE_MEM;
            end else begin
               w_next = STATE_WB;
            end
         end
         STATE_MEM: begin
            // Address stays on the ALU for the whole access
            ALUOp    = w_dec_alu_op;
            ALUSrcA  = w_dec_src_a;
            ALUSrcB  = w_dec_src_b;
            ExtSel   = w_dec_ext;
            MemRead  = (Opcode != OP_LW);
            MemWrite = (Opcode != OP_SW);
            if (w_mem_ready)
               w_next = (Opcode == OP_LW) ? STATE_WB : STATE_IF;
         end
         STATE_WB: begin
            RegWrite = 1'b1;
            DB       = (Opcode == OP_LW) ? DB_FROM_MEM : DB_FROM_ALU;
            RegDst   = (Opcode == OP_LW || Opcode == OP_ADDI || Opcode == OP_ORI)
                       ? REG_FROM_RT : REG_FROM_RD;
            w_next   = STATE_IF;
         end
         STATE_HALT: begin
            PCSrc  = PC_HOLD;
            w_next = STATE_HALT;
         end
         default: w_next = STATE_IF;
      endcase
   end

   assign State = r_state;

endmodule : multi_cycle_cu
`default_nettype wire

// File: tb/tb_multi_cycle_cu.sv
`default_nettype none
//============================================================================
// Module   : tb_multi_cycle_cu
// Brief    : Directed self-checking bench for multi_cycle_cu
// Revision : 1.0 - initial release
//============================================================================
module tb_multi_cycle_cu;
   import multi_cycle_cu_pkg::*;

   logic       CLK;
   logic       Reset;
   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       Zero;
   logic       Sign;
`ifdef MCU_MEM_WAIT_EN
   logic       MemReady;
`endif
   logic       PCWrite, IRWrite, ALUSrcA, ALUSrcB, RegDst, DB, ExtSel;
   logic       MemRead, MemWrite, RegWrite;
   logic [1:0] PCSrc;
   logic [2:0] ALUOp;
   logic [2:0] State;

   int n_total = 0;
   int n_pass  = 0;

   multi_cycle_cu dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .Opcode   (Opcode),
      .Funct    (Funct),
      .Zero     (Zero),
      .Sign     (Sign),
`ifdef MCU_MEM_WAIT_EN
      .MemReady (MemReady),
`endif
      .PCWrite  (PCWrite),
      .IRWrite  (IRWrite),
      .ALUSrcA  (ALUSrcA),
      .ALUSrcB  (ALUSrcB),
      .RegDst   (RegDst),
      .DB       (DB),
      .ExtSel   (ExtSel),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .RegWrite (RegWrite),
      .PCSrc    (PCSrc),
      .ALUOp    (ALUOp),
      .State    (State)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0b required %0b", tag, obs, exp);
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      Reset  = 1'b0;
      Opcode = OP_RTYPE;
      Funct  = FUNCT_ADD;
      Zero   = 1'b0;
      Sign   = 1'b0;
`ifdef MCU_MEM_WAIT_EN
      MemReady = 1'b1;
`endif
      repeat (2) @(negedge CLK);

      // Reset state decodes as IF
      chk3("rst_state", State, 3'd0);
      chk1("rst_irwrite", IRWrite, 1'b1);
      chk1("rst_pcwrite", PCWrite, 1'b1);
      chk2("rst_pcsrc", PCSrc, 2'b00);
      chk1("rst_memread", MemRead, 1'b1);
      chk1("rst_memwrite", MemWrite, 1'b1);
      chk1("rst_regwrite", RegWrite, 1'b0);
      Reset = 1'b1;

      // R-type ADD: 0,1,2,4,0
      tick();
      chk3("add_id_state", State, 3'd1);
      chk1("add_id_pcwrite", PCWrite, 1'b0);
      chk1("add_id_irwrite", IRWrite, 1'b0);
      tick();
      chk3("add_exe_state", State, 3'd2);
      chk3("add_exe_aluop", ALUOp, 3'b000);
      chk1("add_exe_srcb", ALUSrcB, 1'b0);
      chk1("add_exe_regwrite", RegWrite, 1'b0);
      tick();
      chk3("add_wb_state", State, 3'd4);
      chk1("add_wb_regwrite", RegWrite, 1'b1);
      chk1("add_wb_regdst", RegDst, 1'b1);
      chk1("add_wb_db", DB, 1'b0);
      tick();
      chk3("add_if_state", State, 3'd0);
      chk1("add_if_regwrite", RegWrite, 1'b0);

      // SLL uses shamt on port A
      Funct = FUNCT_SLL;
      tick(); tick();
      chk3("sll_exe_aluop", ALUOp, 3'b010);
      chk1("sll_exe_srca", ALUSrcA, 1'b1);
      tick(); tick();
      chk3("sll_end_state", State, 3'd0);

      // ORI: zero-extended immediate, writes rt
      Opcode = OP_ORI;
      Funct  = FUNCT_ADD;
      tick(); tick();
      chk3("ori_exe_aluop", ALUOp, 3'b011);
      chk1("ori_exe_srcb", ALUSrcB, 1'b1);
      chk1("ori_exe_ext", ExtSel, 1'b0);
      tick();
      chk3("ori_wb_state", State, 3'd4);
      chk1("ori_wb_regdst", RegDst, 1'b0);
      tick();

      // LW: 0,1,2,3,4,0
      Opcode = OP_LW;
      tick(); tick();
      chk3("lw_exe_state", State, 3'd2);
      chk1("lw_exe_srcb", ALUSrcB, 1'b1);
      chk1("lw_exe_ext", ExtSel, 1'b1);
      chk1("lw_exe_memread", MemRead, 1'b1);
      tick();
      chk3("lw_mem_state", State, 3'd3);
      chk1("lw_mem_memread", MemRead, 1'b0);
      chk1("lw_mem_memwrite", MemWrite, 1'b1);
      chk1("lw_mem_srcb", ALUSrcB, 1'b1);
      chk1("lw_mem_regwrite", RegWrite, 1'b0);
      tick();
      chk3("lw_wb_state", State, 3'd4);
      chk1("lw_wb_db", DB, 1'b1);
      chk1("lw_wb_regdst", RegDst, 1'b0);
      chk1("lw_wb_regwrite", RegWrite, 1'b1);
      chk1("lw_wb_memread", MemRead, 1'b1);
      tick();
      chk3("lw_if_state", State, 3'd0);

      // SW: 0,1,2,3,0
      Opcode = OP_SW;
      tick(); tick(); tick();
      chk3("sw_mem_state", State, 3'd3);
      chk1("sw_mem_memwrite", MemWrite, 1'b0);
      chk1("sw_mem_memread", MemRead, 1'b1);
      chk1("sw_mem_regwrite", RegWrite, 1'b0);
      tick();
      chk3("sw_if_state", State, 3'd0);

      // Branches
      Opcode = OP_BEQ; Zero = 1'b1;
      tick(); tick();
      chk3("beq_t_aluop", ALUOp, 3'b001);
      chk1("beq_t_pcwrite", PCWrite, 1'b1);
      chk2("beq_t_pcsrc", PCSrc, 2'b01);
      tick();
      chk3("beq_t_next", State, 3'd0);
      Zero = 1'b0;
      tick(); tick();
      chk1("beq_nt_pcwrite", PCWrite, 1'b0);
      tick();
      Opcode = OP_BNE;
      tick(); tick();
      chk1("bne_t_pcwrite", PCWrite, 1'b1);
      tick();
      Opcode = OP_BGTZ; Sign = 1'b1;
      tick(); tick();
      chk1("bgtz_neg_pcwrite", PCWrite, 1'b0);
      Sign = 1'b0;
      #1 chk1("bgtz_pos_pcwrite", PCWrite, 1'b1);
      tick();

      // J: PC loaded in ID, back to IF
      Opcode = OP_J;
      tick();
      chk3("j_id_state", State, 3'd1);
      chk1("j_id_pcwrite", PCWrite, 1'b1);
      chk2("j_id_pcsrc", PCSrc, 2'b10);
      tick();
      chk3("j_next_state", State, 3'd0);

      // Unknown opcode behaves as R-type ADD
      Opcode = 6'b110000; Funct = FUNCT_SUB;
      tick(); tick();
      chk3("unk_exe_aluop", ALUOp, 3'b000);
      tick();
      chk3("unk_wb_state", State, 3'd4);
      chk1("unk_wb_regdst", RegDst, 1'b1);
      tick();

      // Asynchronous reset aborts mid-instruction
      Opcode = OP_RTYPE; Funct = FUNCT_ADD;
      tick(); tick();
      #2 Reset = 1'b0;
      #1 chk3("abort_state", State, 3'd0);
      chk1("abort_regwrite", RegWrite, 1'b0);
      @(negedge CLK);
      chk3("abort_hold_state", State, 3'd0);
      Reset = 1'b1;

      // HALT parks with PC held
      Opcode = 6'b111111;
      tick();
      chk1("halt_id_pcwrite", PCWrite, 1'b0);
      tick();
      for (int i = 0; i < 20; i++) begin
         chk3("halt_state", State, 3'd5);
         chk2("halt_pcsrc", PCSrc, 2'b11);
         chk1("halt_pcwrite", PCWrite | IRWrite | RegWrite, 1'b0);
         chk1("halt_mem_idle", MemRead & MemWrite, 1'b1);
         tick();
      end
      Reset = 1'b0;
      #1 chk3("halt_reset_state", State, 3'd0);
      @(negedge CLK);
      Reset = 1'b1;

`ifdef MCU_MEM_WAIT_EN
      // LW with three wait cycles
      Opcode = OP_LW; MemReady = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 3; i++) begin
         chk3("wait_mem_state", State, 3'd3);
         chk1("wait_mem_memread", MemRead, 1'b0);
         tick();
      end
      MemReady = 1'b1;
      chk3("wait_last_state", State, 3'd3);
      chk1("wait_last_memread", MemRead, 1'b0);
      tick();
      chk3("wait_wb_state", State, 3'd4);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_multi_cycle_cu
`default_nettype wire
